// File: rtl/counter_bank_if.sv
// Bundle of the add/clear/read signals of counter_bank.
// master = writer/host side, slave = counter bank side.
interface counter_bank_if #(
  parameter int unsigned WIDTH     = 32,
  parameter int unsigned CHANNELS  = 4,
  localparam int unsigned CHAN_BITS = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) ();
  logic                 add_valid;
  logic [CHAN_BITS-1:0] add_chan;
  logic [WIDTH-1:0]     add_amount;
  logic                 clear_valid;
  logic [CHAN_BITS-1:0] clear_chan;
  logic                 read_req;
  logic [CHAN_BITS-1:0] read_chan;
  logic                 read_ack;
  logic [WIDTH-1:0]     read_data;
  logic                 read_ovf;
  logic                 any_ovf;
  logic [WIDTH-1:0]     total;

  modport master (
    output add_valid, add_chan, add_amount, clear_valid, clear_chan, read_req, read_chan,
    input  read_ack, read_data, read_ovf, any_ovf, total
  );

  modport slave (
    input  add_valid, add_chan, add_amount, clear_valid, clear_chan, read_req, read_chan,
    output read_ack, read_data, read_ovf, any_ovf, total
  );
endinterface

// File: rtl/counter_bank.sv
// Bank of CHANNELS WIDTH-bit accumulating counters with sticky overflow, registered readback
// and combinational wrapping total. Define COUNTER_BANK_SATURATE_EN for saturating adds.
module counter_bank #(
  parameter int unsigned WIDTH     = 32,
  parameter int unsigned CHANNELS  = 4,
  localparam int unsigned CHAN_BITS = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
  input logic           clock,
  input logic           reset,
  counter_bank_if.slave bus
);

  logic [WIDTH-1:0]    count      [CHANNELS];
  logic [WIDTH-1:0]    count_next [CHANNELS];
  logic [CHANNELS-1:0] ovf;
  logic [CHANNELS-1:0] ovf_next;
  logic [WIDTH-1:0]    read_mux_data;
  logic                read_mux_ovf;
  logic [WIDTH-1:0]    total_sum;
  logic                read_ack_q;
  logic [WIDTH-1:0]    read_data_q;
  logic                read_ovf_q;

  // Channel matching by per-index compare: out-of-range channel numbers never match.
  always_comb begin
    logic [WIDTH:0] sum;
    sum = '0;
    for (int unsigned i = 0; i < CHANNELS; i++) begin
      count_next[i] = count[i];
      ovf_next[i]   = ovf[i];
      sum           = {1'b0, count[i]} + {1'b0, bus.add_amount};
      if (bus.clear_valid && (bus.clear_chan == CHAN_BITS'(i))) begin
        count_next[i] = '0;
        ovf_next[i]   = 1'b0;
      end else if (bus.add_valid && (bus.add_chan == CHAN_BITS'(i))) begin
`ifdef COUNTER_BANK_SATURATE_EN
        count_next[i] = sum[WIDTH] ? '1 : sum[WIDTH-1:0];
`else
        count_next[i] = sum[WIDTH-1:0];
`endif
        ovf_next[i]   = ovf[i] | sum[WIDTH];
      end
    end
  end

  always_comb begin
    read_mux_data = '0;
    read_mux_ovf  = 1'b0;
    for (int unsigned i = 0; i < CHANNELS; i++) begin
      if (bus.read_chan == CHAN_BITS'(i)) begin
        read_mux_data = count[i];
        read_mux_ovf  = ovf[i];
      end
    end
  end

  always_comb begin
    total_sum = '0;
    for (int unsigned i = 0; i < CHANNELS; i++) begin
      total_sum = total_sum + count[i];
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      for (int unsigned i = 0; i < CHANNELS; i++) begin
        count[i] <= '0;
      end
      ovf         <= '0;
      read_ack_q  <= 1'b0;
      read_data_q <= '0;
      read_ovf_q  <= 1'b0;
    end else begin
      for (int unsigned i = 0; i < CHANNELS; i++) begin
        count[i] <= count_next[i];
      end
      ovf        <= ovf_next;
      read_ack_q <= bus.read_req;
      // Readback samples pre-update state so a same-cycle add/clear is not visible.
      if (bus.read_req) begin
        read_data_q <= read_mux_data;
        read_ovf_q  <= read_mux_ovf;
      end
    end
  end

  assign bus.read_ack  = read_ack_q;
  assign bus.read_data = read_data_q;
  assign bus.read_ovf  = read_ovf_q;
  assign bus.total     = total_sum;
  assign bus.any_ovf   = |ovf;

endmodule
